// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong game engine: FSM state encoding,
// position width, signed position/direction types.
package pong_pkg;

  localparam int POS_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    POINT,
    SERVE_WAIT,
    GAME_OVER
  } pong_state_t;

  // Ball direction per axis: +1 or -1.
  typedef logic signed [1:0] dir_t;
  localparam dir_t DIR_POS = 2'sb01;
  localparam dir_t DIR_NEG = 2'sb11;

  // One extra bit so that under/overflow of a screen coordinate is visible as a sign.
  typedef logic signed [POS_W:0] spos_t;

  function automatic spos_t to_spos(input logic [POS_W-1:0] p);
    return spos_t'({1'b0, p});
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: moves PADDLE_SPEED px per frame on up or dn, clamped to the
// visible area; both or neither pressed holds the paddle.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int V_RES        = 480,
  parameter int PADDLE_H     = 50,
  parameter int PADDLE_SPEED = 3
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             up,
  input  logic             dn,
  output logic [POS_W-1:0] paddle_y
);

  localparam logic [POS_W-1:0] Y_RESET = POS_W'((V_RES - PADDLE_H) / 2);
  localparam spos_t            Y_MAX   = spos_t'(V_RES - PADDLE_H);
  localparam spos_t            SPEED   = spos_t'(PADDLE_SPEED);

  spos_t            cur_s;
  spos_t            up_s;
  spos_t            dn_s;
  logic [POS_W-1:0] y_d;

  assign cur_s = to_spos(paddle_y);
  assign up_s  = cur_s - SPEED;
  assign dn_s  = cur_s + SPEED;

  // Next paddle position with clamping at the top and bottom of the screen.
  always_comb begin
    y_d = paddle_y;
    if (up && !dn) begin
      y_d = (up_s < spos_t'(0)) ? '0 : up_s[POS_W-1:0];
    end else if (dn && !up) begin
      y_d = (dn_s > Y_MAX) ? Y_MAX[POS_W-1:0] : dn_s[POS_W-1:0];
    end
  end

  // Paddle register, updated once per frame.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      paddle_y <= Y_RESET;
    end else if (frame_tick) begin
      paddle_y <= y_d;
    end
  end

endmodule

// File: rtl/pong_game_engine.sv
// Frame-rate Pong engine: ball motion, paddle/wall bounces, misses, scoring,
// serve sequencing and win detection. All state advances on frame_tick only.
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 50,
  parameter int P1_X         = 20,
  parameter int P2_X         = 610,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_SPEED = 3,
  parameter int BALL_VX      = 3,
  parameter int BALL_VY      = 1,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_DELAY  = 60,
  parameter int SCORE_W      = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               p1_up,
  input  logic               p1_dn,
  input  logic               p2_up,
  input  logic               p2_dn,
  input  logic               serve_p1,
  input  logic               serve_p2,
  input  logic               new_game,
  output logic [POS_W-1:0]   ball_x,
  output logic [POS_W-1:0]   ball_y,
  output logic [POS_W-1:0]   p1_y,
  output logic [POS_W-1:0]   p2_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state_o
);

  localparam logic [POS_W-1:0] BX0 = POS_W'(H_RES / 2 - BALL_SIZE / 2);
  localparam logic [POS_W-1:0] BY0 = POS_W'(V_RES / 2 - BALL_SIZE / 2);

  localparam spos_t HR      = spos_t'(H_RES);
  localparam spos_t VR      = spos_t'(V_RES);
  localparam spos_t BS      = spos_t'(BALL_SIZE);
  localparam spos_t VX      = spos_t'(BALL_VX);
  localparam spos_t VY      = spos_t'(BALL_VY);
  localparam spos_t PW      = spos_t'(PADDLE_W);
  localparam spos_t PH      = spos_t'(PADDLE_H);
  localparam spos_t P1X     = spos_t'(P1_X);
  localparam spos_t P2X     = spos_t'(P2_X);
  localparam spos_t P1_EDGE = spos_t'(P1_X + PADDLE_W);
  localparam spos_t P2_EDGE = spos_t'(P2_X - BALL_SIZE);
  localparam spos_t Y_BOT   = spos_t'(V_RES - BALL_SIZE);

  localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
  localparam int                 CNT_W    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY - 1);

  pong_state_t        state_q, state_d;
  dir_t               dx_q, dx_d, dy_q, dy_d;
  logic [POS_W-1:0]   bx_d, by_d;
  logic [SCORE_W-1:0] s1_d, s2_d, s1_inc, s2_inc;
  logic               win_d;
  logic               p2sc_q, p2sc_d;   // 1 when the last point went to P2
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  spos_t bx_s, by_s, p1_s, p2_s, step_x, step_y, nx, ny;
  logic  miss_l, miss_r, hit_p1, hit_p2, wall_t, wall_b;

  pong_paddle_ctrl #(
    .V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)
  ) u_paddle1 (
    .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick),
    .up(p1_up), .dn(p1_dn), .paddle_y(p1_y)
  );

  pong_paddle_ctrl #(
    .V_RES(V_RES), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)
  ) u_paddle2 (
    .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick),
    .up(p2_up), .dn(p2_dn), .paddle_y(p2_y)
  );

  assign bx_s = to_spos(ball_x);
  assign by_s = to_spos(ball_y);
  assign p1_s = to_spos(p1_y);
  assign p2_s = to_spos(p2_y);

  assign step_x = (dx_q == DIR_NEG) ? bx_s - VX : bx_s + VX;
  assign step_y = (dy_q == DIR_NEG) ? by_s - VY : by_s + VY;

  // Collision tests on the current ball and paddle positions.
  assign miss_l = (dx_q == DIR_NEG) && (bx_s < VX);
  assign miss_r = (dx_q == DIR_POS) && (bx_s + BS > HR - VX);
  assign hit_p1 = (dx_q == DIR_NEG) && (bx_s <= P1X + PW) && (bx_s + BS > P1X)
                  && (by_s < p1_s + PH) && (by_s + BS > p1_s);
  assign hit_p2 = (dx_q == DIR_POS) && (bx_s + BS >= P2X) && (bx_s < P2X + PW)
                  && (by_s < p2_s + PH) && (by_s + BS > p2_s);
  assign wall_t = (dy_q == DIR_NEG) && (by_s < VY);
  assign wall_b = (dy_q == DIR_POS) && (by_s + BS > VR - VY);

  assign s1_inc = (score1 == WIN_S) ? score1 : score1 + SCORE_W'(1);
  assign s2_inc = (score2 == WIN_S) ? score2 : score2 + SCORE_W'(1);

  assign game_over = (state_q == GAME_OVER);
  assign state_o   = state_q;

  // Next-state and datapath decisions for one frame.
  always_comb begin
    state_d = state_q;
    bx_d    = ball_x;
    by_d    = ball_y;
    dx_d    = dx_q;
    dy_d    = dy_q;
    s1_d    = score1;
    s2_d    = score2;
    win_d   = winner;
    p2sc_d  = p2sc_q;
    cnt_d   = cnt_q;
    nx      = bx_s;
    ny      = by_s;
    case (state_q)
      IDLE: begin
        bx_d = BX0;
        by_d = BY0;
        if (serve_p1) begin
          dx_d    = DIR_POS;
          dy_d    = DIR_NEG;
          state_d = PLAY;
        end else if (serve_p2) begin
          dx_d    = DIR_NEG;
          dy_d    = DIR_NEG;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (miss_l) begin
          p2sc_d  = 1'b1;
          state_d = POINT;
        end else if (miss_r) begin
          p2sc_d  = 1'b0;
          state_d = POINT;
        end else begin
          if (hit_p1) begin
            nx   = P1_EDGE;
            dx_d = DIR_POS;
          end else if (hit_p2) begin
            nx   = P2_EDGE;
            dx_d = DIR_NEG;
          end else begin
            nx = step_x;
          end
          // Wall handling is independent of the paddle so corner hits bounce both axes.
          if (wall_t) begin
            ny   = '0;
            dy_d = DIR_POS;
          end else if (wall_b) begin
            ny   = Y_BOT;
            dy_d = DIR_NEG;
          end else begin
            ny = step_y;
          end
          bx_d = nx[POS_W-1:0];
          by_d = ny[POS_W-1:0];
        end
      end
      POINT: begin
        bx_d  = BX0;
        by_d  = BY0;
        cnt_d = '0;
        if (p2sc_q) begin
          s2_d = s2_inc;
        end else begin
          s1_d = s1_inc;
        end
        if ((p2sc_q ? s2_inc : s1_inc) == WIN_S) begin
          win_d   = p2sc_q;
          state_d = GAME_OVER;
        end else begin
          state_d = SERVE_WAIT;
        end
      end
      SERVE_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          // Serve toward the player who conceded the point.
          dx_d    = p2sc_q ? DIR_NEG : DIR_POS;
          dy_d    = DIR_NEG;
          state_d = PLAY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAME_OVER: begin
        bx_d = BX0;
        by_d = BY0;
        if (new_game) begin
          s1_d    = '0;
          s2_d    = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Game state registers, updated once per frame.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ball_x  <= BX0;
      ball_y  <= BY0;
      dx_q    <= DIR_POS;
      dy_q    <= DIR_NEG;
      score1  <= '0;
      score2  <= '0;
      winner  <= 1'b0;
      p2sc_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (frame_tick) begin
      state_q <= state_d;
      ball_x  <= bx_d;
      ball_y  <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      score1  <= s1_d;
      score2  <= s2_d;
      winner  <= win_d;
      p2sc_q  <= p2sc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pong_game_engine.sv
// Bench for pong_game_engine: a frame-level reference model predicts every
// output after each frame_tick; predictions are queued at drive time and
// compared when the DUT has registered the frame. Directed checks cover
// reset, serve tie, paddle clamps, bounce, miss, re-serve, walls and win.
module tb_pong_game_engine;

  localparam int W = 53;
  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_POINT = 2, ST_SW = 3, ST_GO = 4;
  localparam logic [W-1:0] RST_VEC = {10'd316, 10'd236, 10'd215, 10'd215,
                                      4'd0, 4'd0, 1'b0, 1'b0, 3'd0};

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic       serve_p1 = 1'b0, serve_p2 = 1'b0, new_game = 1'b0;
  logic [9:0] ball_x, ball_y, p1_y, p2_y;
  logic [3:0] score1, score2;
  logic       game_over, winner;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  int m_st, m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_win, m_dx, m_dy, m_cnt, m_p2sc;
  int min_x, max_x, min_y, max_y;

  always #5 CLOCK_50 = ~CLOCK_50;

  pong_game_engine dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .serve_p1(serve_p1), .serve_p2(serve_p2), .new_game(new_game),
    .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
    .score1(score1), .score2(score2), .game_over(game_over),
    .winner(winner), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {ball_x, ball_y, p1_y, p2_y, score1, score2, game_over, winner, state_o};
  endfunction

  function automatic logic [W-1:0] model_vec();
    return {10'(m_bx), 10'(m_by), 10'(m_p1), 10'(m_p2), 4'(m_s1), 4'(m_s2),
            (m_st == ST_GO), 1'(m_win), 3'(m_st)};
  endfunction

  task automatic model_reset();
    m_st = ST_IDLE; m_bx = 316; m_by = 236; m_p1 = 215; m_p2 = 215;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_dx = 1; m_dy = -1; m_cnt = 0; m_p2sc = 0;
  endtask

  function automatic int pad(input int p, input logic u, input logic d);
    if (u && !d) return (p - 3 < 0) ? 0 : p - 3;
    if (d && !u) return (p + 3 > 430) ? 430 : p + 3;
    return p;
  endfunction

  task automatic model_step(input logic u1, d1, u2, d2, s1, s2, ng);
    int np1, np2, nx, ny;
    np1 = pad(m_p1, u1, d1);
    np2 = pad(m_p2, u2, d2);
    case (m_st)
      ST_IDLE: begin
        m_bx = 316; m_by = 236;
        if (s1) begin m_dx = 1; m_dy = -1; m_st = ST_PLAY; end
        else if (s2) begin m_dx = -1; m_dy = -1; m_st = ST_PLAY; end
      end
      ST_PLAY: begin
        if (m_dx < 0 && m_bx < 3) begin m_p2sc = 1; m_st = ST_POINT; end
        else if (m_dx > 0 && m_bx + 8 > 637) begin m_p2sc = 0; m_st = ST_POINT; end
        else begin
          if (m_dx < 0 && m_bx <= 30 && m_bx + 8 > 20 && m_by < m_p1 + 50 && m_by + 8 > m_p1) begin
            nx = 30; m_dx = 1;
          end else if (m_dx > 0 && m_bx + 8 >= 610 && m_bx < 620 && m_by < m_p2 + 50 && m_by + 8 > m_p2) begin
            nx = 602; m_dx = -1;
          end else begin
            nx = m_bx + 3 * m_dx;
          end
          if (m_dy < 0 && m_by < 1) begin ny = 0; m_dy = 1; end
          else if (m_dy > 0 && m_by + 8 > 479) begin ny = 472; m_dy = -1; end
          else ny = m_by + m_dy;
          m_bx = nx; m_by = ny;
        end
      end
      ST_POINT: begin
        m_bx = 316; m_by = 236; m_cnt = 0;
        if (m_p2sc != 0) begin
          if (m_s2 < 7) m_s2++;
          if (m_s2 == 7) begin m_win = 1; m_st = ST_GO; end else m_st = ST_SW;
        end else begin
          if (m_s1 < 7) m_s1++;
          if (m_s1 == 7) begin m_win = 0; m_st = ST_GO; end else m_st = ST_SW;
        end
      end
      ST_SW: begin
        if (m_cnt == 59) begin
          m_dx = (m_p2sc != 0) ? -1 : 1; m_dy = -1; m_st = ST_PLAY;
        end else m_cnt++;
      end
      default: begin
        m_bx = 316; m_by = 236;
        if (ng) begin m_s1 = 0; m_s2 = 0; m_st = ST_IDLE; end
      end
    endcase
    m_p1 = np1;
    m_p2 = np2;
  endtask

  // Drives one frame, queues the prediction, then compares once the DUT has registered it.
  task automatic do_tick(input logic u1, d1, u2, d2, s1, s2, ng);
    logic [W-1:0] e;
    p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
    serve_p1 = s1; serve_p2 = s2; new_game = ng;
    model_step(u1, d1, u2, d2, s1, s2, ng);
    exp_q.push_back(model_vec());
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;
    serve_p1 = 0; serve_p2 = 0; new_game = 0;
    @(negedge CLOCK_50);
    e = exp_q.pop_front();
    check("frame", 64'(dut_vec()), 64'(e));
    if (int'(ball_x) < min_x) min_x = int'(ball_x);
    if (int'(ball_x) > max_x) max_x = int'(ball_x);
    if (int'(ball_y) < min_y) min_y = int'(ball_y);
    if (int'(ball_y) > max_y) max_y = int'(ball_y);
  endtask

  // Paddle tracking used to keep a long rally alive.
  task automatic track(input int p, output logic u, output logic d);
    u = 1'b0; d = 1'b0;
    if (p + 25 < m_by + 2) d = 1'b1;
    else if (p + 25 > m_by + 6) u = 1'b1;
  endtask

  initial begin
    int   n;
    logic t1u, t1d, t2u, t2d;
    model_reset();
    min_x = 1023; max_x = 0; min_y = 1023; max_y = 0;

    // Reset, with a frame_tick and a serve that must be ignored while reset is high.
    repeat (2) @(negedge CLOCK_50);
    frame_tick = 1'b1; serve_p1 = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0; serve_p1 = 1'b0;
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("reset_state", 64'(dut_vec()), 64'(RST_VEC));

    repeat (3) do_tick(0, 0, 0, 0, 0, 0, 0);
    check("idle_centre", 64'({ball_x, ball_y, p1_y, p2_y, state_o}),
          64'({10'd316, 10'd236, 10'd215, 10'd215, 3'd0}));
    repeat (3) do_tick(1, 1, 1, 1, 0, 0, 0);
    check("hold_both", 64'({p1_y, p2_y}), 64'({10'd215, 10'd215}));

    // Simultaneous serve: P1 wins the tie, ball heads right and up.
    do_tick(0, 0, 0, 0, 1, 1, 0);
    check("serve_tie_state", 64'(state_o), 64'(ST_PLAY));
    do_tick(0, 0, 0, 0, 0, 0, 0);
    check("serve_tie_move", 64'({ball_x, ball_y}), 64'({10'd319, 10'd235}));

    repeat (80) do_tick(1, 0, 0, 1, 0, 0, 0);
    check("p1_top_clamp", 64'(p1_y), 64'(0));
    check("p2_bot_clamp", 64'(p2_y), 64'(430));
    repeat (3) do_tick(1, 1, 0, 0, 0, 0, 0);
    check("p1_hold_at_top", 64'(p1_y), 64'(0));

    // P2 paddle parked at the bottom: P1 scores every rally until the win.
    n = 0;
    while (m_st != ST_GO && n < 3000) begin
      do_tick(0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    check("reach_game_over", 64'(state_o), 64'(ST_GO));
    check("p1_wins", 64'({score1, game_over, winner}), 64'({4'd7, 1'b1, 1'b0}));
    do_tick(0, 0, 0, 0, 0, 0, 1);
    check("new_game", 64'({score1, score2, state_o, game_over}),
          64'({4'd0, 4'd0, 3'd0, 1'b0}));

    // P2 serves left with P1's paddle out of the way: P2 scores.
    do_tick(0, 0, 0, 0, 0, 1, 0);
    n = 0;
    while (m_st != ST_SW && n < 400) begin
      do_tick(0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    check("p2_point", 64'({score1, score2, state_o}), 64'({4'd0, 4'd1, 3'd3}));
    for (int i = 0; i < 60; i++) begin
      do_tick(0, 0, 0, 0, (i < 3), (i < 3), 0);
      if (i == 58) check("serve_wait_hold", 64'(state_o), 64'(ST_SW));
    end
    check("auto_serve", 64'(state_o), 64'(ST_PLAY));

    // Long rally with both paddles tracking: P1 bounce, then top and bottom walls.
    for (int k = 1; k <= 1100; k++) begin
      track(m_p1, t1u, t1d);
      track(m_p2, t2u, t2d);
      do_tick(t1u, t1d, t2u, t2d, 0, 0, 0);
      if (k == 1) check("serve_left", 64'(ball_x), 64'(313));
      if (k == 97) check("p1_bounce", 64'({ball_x, score1, score2}),
                         64'({10'd30, 4'd0, 4'd1}));
      if (k == 98) check("bounce_dir", 64'(ball_x), 64'(33));
    end
    check("top_wall", 64'(min_y), 64'(0));
    check("bottom_wall", 64'(max_y), 64'(472));
    check("right_edge", 64'(max_x), 64'(631));
    check("left_edge", 64'(min_x), 64'(1));
    check("rally_state", 64'(state_o), 64'(ST_PLAY));

    // Reset mid-rally takes effect without waiting for a clock edge.
    reset = 1'b1;
    #1;
    check("mid_rally_reset", 64'(dut_vec()), 64'(RST_VEC));
    model_reset();
    exp_q.delete();
    @(negedge CLOCK_50);
    frame_tick = 1'b1; serve_p2 = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0; serve_p2 = 1'b0;
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("reset_tick_ignored", 64'(dut_vec()), 64'(RST_VEC));
    do_tick(0, 0, 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
